// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use / branch / halt hazard control for a 5-stage pipeline
//
// Purpose: decides per cycle whether the front end stalls, which pipeline
// registers are flushed, and sequences the HALT drain down to a stopped state.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-low reset
//   id_rs1/rs2   in   ID-stage source register addresses (REG_AW)
//   id_use_rs1/2 in   ID instruction actually reads that source
//   id_halt      in   HALT decoded in ID
//   ex_rd        in   EX-stage destination register (REG_AW)
//   ex_mem_read  in   EX instruction is a load
//   ex_br_taken  in   branch/jump resolved taken in EX
//   stop_pc      out  hold PC
//   ifid_hold    out  IF/ID keeps its contents
//   ifid_flush   out  IF/ID loaded with NOP
//   idex_flush   out  ID/EX loaded with NOP
//   halted       out  pipeline drained and stopped
//   stall_cnt    out  16-bit stall-cycle counter
//
// Configuration: define PIPE_HAZARD_STALL_CNT_EN to build the stall counter;
// otherwise stall_cnt is constant 0 and no counter flops exist.

module pipe_hazard_ctrl #(
   parameter int REG_AW    = 4,
   parameter int DRAIN_CYC = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic              id_halt,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_mem_read,
   input  logic              ex_br_taken,
   output logic              stop_pc,
   output logic              ifid_hold,
   output logic              ifid_flush,
   output logic              idex_flush,
   output logic              halted,
   output logic [15:0]       stall_cnt
);

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      HALT_DRAIN = 2'd1,
      HALTED     = 2'd2
   } state_t;

   // Wide enough to hold DRAIN_CYC-1.
   localparam int CW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

   state_t        state;
   logic [CW-1:0] drain_cnt;
   logic          load_use;
   logic          halt_go;

   // x0 is hard-wired zero, so a load into it never creates a dependency.
   assign load_use = ex_mem_read && (ex_rd != '0) &&
                     ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                      (id_use_rs2 && (id_rs2 == ex_rd)));

   // HALT is accepted only in a clean cycle; when it coincides with a load-use
   // the bubble is inserted first and HALT is seen again next cycle.
   assign halt_go = (state == RUN) && id_halt && !ex_br_taken && !load_use;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= RUN;
         drain_cnt <= '0;
      end else begin
         case (state)
            RUN: begin
               if (halt_go) begin
                  state     <= HALT_DRAIN;
                  drain_cnt <= CW'(DRAIN_CYC - 1);
               end
            end
            HALT_DRAIN: begin
               // DRAIN_CYC drain cycles in total: counts DRAIN_CYC-1 down to 0.
               if (drain_cnt == '0) begin
                  state <= HALTED;
               end else begin
                  drain_cnt <= drain_cnt - 1'b1;
               end
            end
            HALTED: begin
               state <= HALTED;
            end
            default: begin
               state     <= RUN;
               drain_cnt <= '0;
            end
         endcase
      end
   end

   // Control outputs are combinational so the stall/flush lands in the same
   // cycle the hazard is visible. Reset forces every control low.
   always_comb begin
      stop_pc    = 1'b0;
      ifid_hold  = 1'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      halted     = 1'b0;
      if (rst) begin
         case (state)
            RUN: begin
               if (ex_br_taken) begin
                  ifid_flush = 1'b1;
                  idex_flush = 1'b1;
               end else if (load_use) begin
                  stop_pc    = 1'b1;
                  ifid_hold  = 1'b1;
                  idex_flush = 1'b1;
               end else if (id_halt) begin
                  stop_pc    = 1'b1;
                  ifid_hold  = 1'b1;
               end
            end
            HALT_DRAIN: begin
               stop_pc    = 1'b1;
               ifid_hold  = 1'b1;
               idex_flush = 1'b1;
            end
            HALTED: begin
               stop_pc    = 1'b1;
               ifid_hold  = 1'b1;
               idex_flush = 1'b1;
               halted     = 1'b1;
            end
            default: begin
               stop_pc = 1'b0;
            end
         endcase
      end
   end

`ifdef PIPE_HAZARD_STALL_CNT_EN
   logic [15:0] stall_q;

   // Counts every PC-hold cycle up to and including the drain; frozen once halted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_q <= 16'd0;
      end else if (stop_pc && (state != HALTED) && (stall_q != 16'hFFFF)) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

   logic        clk;
   logic        rst;
   logic [3:0]  id_rs1, id_rs2, ex_rd;
   logic        id_use_rs1, id_use_rs2, id_halt, ex_mem_read, ex_br_taken;
   logic        stop_pc, ifid_hold, ifid_flush, idex_flush, halted;
   logic [15:0] stall_cnt;

   int tests_run = 0;
   int tests_failed = 0;

   // Expected output vector order: {stop_pc, ifid_hold, ifid_flush, idex_flush, halted}
   logic [4:0]  exp_q[$];
   bit          chk_q[$];
   logic [15:0] cnt_q[$];
   string       name_q[$];

`ifdef PIPE_HAZARD_STALL_CNT_EN
   localparam logic [15:0] CNT_ONE  = 16'd1;
   localparam logic [15:0] CNT_NINE = 16'd9;
`else
   localparam logic [15:0] CNT_ONE  = 16'd0;
   localparam logic [15:0] CNT_NINE = 16'd0;
`endif

   pipe_hazard_ctrl #(.REG_AW(4), .DRAIN_CYC(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .id_rs1     (id_rs1),
      .id_rs2     (id_rs2),
      .id_use_rs1 (id_use_rs1),
      .id_use_rs2 (id_use_rs2),
      .id_halt    (id_halt),
      .ex_rd      (ex_rd),
      .ex_mem_read(ex_mem_read),
      .ex_br_taken(ex_br_taken),
      .stop_pc    (stop_pc),
      .ifid_hold  (ifid_hold),
      .ifid_flush (ifid_flush),
      .idex_flush (idex_flush),
      .halted     (halted),
      .stall_cnt  (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: outputs are valid mid-cycle, compare at the falling edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [4:0]  e;
         logic [4:0]  a;
         bit          c;
         logic [15:0] ec;
         string       n;
         e  = exp_q.pop_front();
         c  = chk_q.pop_front();
         ec = cnt_q.pop_front();
         n  = name_q.pop_front();
         a  = {stop_pc, ifid_hold, ifid_flush, idex_flush, halted};
         tests_run++;
         if (a !== e) begin
            tests_failed++;
            $display("FAIL %s: outputs got %b expected %b", n, a, e);
         end
         if (c) begin
            tests_run++;
            if (stall_cnt !== ec) begin
               tests_failed++;
               $display("FAIL %s stall_cnt: got %0d expected %0d", n, stall_cnt, ec);
            end
         end
      end
   end

   // One cycle of stimulus: applied just after the rising edge, expectation queued.
   task automatic step(input logic r, input logic mr, input logic [3:0] rd,
                       input logic [3:0] rs1, input logic u1,
                       input logic [3:0] rs2, input logic u2,
                       input logic br, input logic h,
                       input logic [4:0] e, input bit c, input logic [15:0] ec,
                       input string n);
      @(posedge clk);
      #1;
      rst         = r;
      ex_mem_read = mr;
      ex_rd       = rd;
      id_rs1      = rs1;
      id_use_rs1  = u1;
      id_rs2      = rs2;
      id_use_rs2  = u2;
      ex_br_taken = br;
      id_halt     = h;
      exp_q.push_back(e);
      chk_q.push_back(c);
      cnt_q.push_back(ec);
      name_q.push_back(n);
   endtask

   task automatic idle(input logic [4:0] e, input string n);
      step(1, 0, 4'd0, 4'd0, 0, 4'd0, 0, 0, 0, e, 0, 16'd0, n);
   endtask

   task automatic lu(input logic [4:0] e, input string n);
      step(1, 1, 4'd3, 4'd3, 1, 4'd0, 0, 0, 0, e, 0, 16'd0, n);
   endtask

   initial begin
      rst = 1'b0; ex_mem_read = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
      id_use_rs1 = 0; id_use_rs2 = 0; ex_br_taken = 0; id_halt = 0;

      // Reset: controls low even with a hazard on the inputs.
      step(0, 1, 4'd3, 4'd3, 1, 4'd0, 0, 0, 1, 5'b00000, 1, 16'd0, "reset_outputs");
      idle(5'b00000, "idle_after_reset");

      // Load-use on rs1, then on rs2, then no-use and x0 cases.
      lu(5'b11010, "loaduse_rs1");
      idle(5'b00000, "after_loaduse_rs1");
      step(1, 1, 4'd5, 4'd0, 0, 4'd5, 1, 0, 0, 5'b11010, 0, 16'd0, "loaduse_rs2");
      step(1, 1, 4'd5, 4'd0, 0, 4'd5, 0, 0, 0, 5'b00000, 0, 16'd0, "rs2_not_used");
      step(1, 1, 4'd0, 4'd0, 1, 4'd0, 0, 0, 0, 5'b00000, 0, 16'd0, "rd_zero_no_stall");
      step(1, 0, 4'd3, 4'd3, 1, 4'd0, 0, 0, 0, 5'b00000, 0, 16'd0, "not_load_no_stall");
      step(1, 1, 4'd3, 4'd4, 1, 4'd2, 1, 0, 0, 5'b00000, 0, 16'd0, "no_reg_match");

      // Branch priority.
      step(1, 1, 4'd3, 4'd3, 1, 4'd0, 0, 1, 0, 5'b00110, 0, 16'd0, "branch_over_loaduse");
      step(1, 0, 4'd0, 4'd0, 0, 4'd0, 0, 1, 0, 5'b00110, 0, 16'd0, "branch_alone");
      step(1, 1, 4'd3, 4'd3, 1, 4'd0, 0, 1, 1, 5'b00110, 0, 16'd0, "branch_over_all");
      idle(5'b00000, "idle_after_branch");

      // Halt with load-use: bubble first, then halt accepted, 3 drain cycles.
      step(1, 1, 4'd3, 4'd3, 1, 4'd0, 0, 0, 1, 5'b11010, 0, 16'd0, "halt_with_loaduse");
      step(1, 0, 4'd0, 4'd0, 0, 4'd0, 0, 0, 1, 5'b11000, 0, 16'd0, "halt_accept");
      idle(5'b11010, "drain_1");
      idle(5'b11010, "drain_2");
      step(1, 0, 4'd0, 4'd0, 0, 4'd0, 0, 1, 0, 5'b11010, 0, 16'd0, "drain_3_branch_ignored");
      idle(5'b11011, "halted");
      step(1, 1, 4'd3, 4'd3, 1, 4'd0, 0, 1, 1, 5'b11011, 0, 16'd0, "halted_sticky");

      // Reset in the middle of the drain.
      step(0, 0, 4'd0, 4'd0, 0, 4'd0, 0, 0, 0, 5'b00000, 1, 16'd0, "reset_from_halted");
      idle(5'b00000, "release_1");
      step(1, 0, 4'd0, 4'd0, 0, 4'd0, 0, 0, 1, 5'b11000, 0, 16'd0, "halt_accept_2");
      idle(5'b11010, "drain2_1");
      step(0, 0, 4'd0, 4'd0, 0, 4'd0, 0, 0, 0, 5'b00000, 1, 16'd0, "reset_mid_drain");
      idle(5'b00000, "run_after_reset");
      idle(5'b00000, "still_run");
      lu(5'b11010, "loaduse_after_reset");
      idle(5'b00000, "idle_after_reset_lu");

      // Stall counter: 5 load-use stalls, then halt with 3 drain cycles.
      step(0, 0, 4'd0, 4'd0, 0, 4'd0, 0, 0, 0, 5'b00000, 1, 16'd0, "reset_cnt");
      idle(5'b00000, "release_cnt");
      lu(5'b11010, "cnt_lu_1");
      step(1, 0, 4'd0, 4'd0, 0, 4'd0, 0, 0, 0, 5'b00000, 1, CNT_ONE, "cnt_after_first");
      for (int i = 2; i <= 5; i++) begin
         lu(5'b11010, "cnt_lu");
         idle(5'b00000, "cnt_gap");
      end
      step(1, 0, 4'd0, 4'd0, 0, 4'd0, 0, 0, 1, 5'b11000, 0, 16'd0, "cnt_halt");
      idle(5'b11010, "cnt_drain_1");
      idle(5'b11010, "cnt_drain_2");
      idle(5'b11010, "cnt_drain_3");
      step(1, 0, 4'd0, 4'd0, 0, 4'd0, 0, 0, 0, 5'b11011, 1, CNT_NINE, "cnt_halted");
      step(1, 0, 4'd0, 4'd0, 0, 4'd0, 0, 0, 0, 5'b11011, 1, CNT_NINE, "cnt_halted_hold");

      @(posedge clk);
      @(posedge clk);
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
